// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, block geometry and address field helpers for dcache_ctrl
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  localparam int BLOCK_BYTES = 4;
  localparam int OFFSET_W    = 2;

  // Helpers work on a zero-extended 32-bit address; callers size the result.
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_w);
    return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_of(input logic [31:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - direct-mapped line storage with byte-write and block-fill ports
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx,
  output logic [31:0]         rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_off,
  input  logic [7:0]          byte_wdata,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [31:0]         fill_data
);

  logic [31:0]          data_q  [NUM_LINES];
  logic [31:0]          data_d  [NUM_LINES];
  logic [TAG_W-1:0]     tag_q   [NUM_LINES];
  logic [TAG_W-1:0]     tag_d   [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  assign rd_data  = data_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // A fill always wins over a byte write; the controller never asserts both.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      data_d[idx]  = fill_data;
      tag_d[idx]   = fill_tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (byte_we) begin
      data_d[idx][{byte_off, 3'b000} +: 8] = byte_wdata;
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload needs no reset: nothing reads it until valid is set by a fill.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [7:0]        WRITE_DATA,
  output logic [7:0]        READ_DATA,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-3:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
  localparam int BLK_W   = ADDR_W - OFFSET_W;

  state_e              state_q, state_d;
  logic                issued_q, issued_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [BLK_W-1:0]    mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_off;
  logic [31:0]         line_data;
  logic [TAG_W-1:0]    line_tag;
  logic                line_valid;
  logic                line_dirty;
  logic                hit, req, mem_done;
  logic                byte_we, fill_en, busy;
  logic [7:0]          rdata;

  assign cpu_tag   = TAG_W'(tag_of(32'(ADDRESS), INDEX_W));
  assign cpu_index = INDEX_W'(index_of(32'(ADDRESS), INDEX_W));
  assign cpu_off   = offset_of(32'(ADDRESS));

  assign hit      = line_valid && (line_tag == cpu_tag);
  assign req      = READ | WRITE;
  // The issued flag keeps a late-rising memory busy from being taken as completion.
  assign mem_done = issued_q && !MEM_BUSYWAIT;

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk        (CLK),
    .rst_n      (RESET),
    .idx        (cpu_index),
    .rd_data    (line_data),
    .rd_tag     (line_tag),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .byte_we    (byte_we),
    .byte_off   (cpu_off),
    .byte_wdata (WRITE_DATA),
    .fill_en    (fill_en),
    .fill_tag   (cpu_tag),
    .fill_data  (MEM_READDATA)
  );

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    byte_we     = 1'b0;
    fill_en     = 1'b0;
    busy        = 1'b0;
    rdata       = 8'h00;
    case (state_q)
      IDLE: begin
        busy    = req && !hit;
        byte_we = WRITE && hit;
        if (READ && hit) begin
          rdata = line_data[{cpu_off, 3'b000} +: 8];
        end
        if (req && !hit) begin
          issued_d = 1'b0;
          if (line_valid && line_dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {line_tag, cpu_index};
            mem_wdata_d = line_data;
          end else begin
            state_d    = FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = ADDRESS[ADDR_W-1:OFFSET_W];
          end
        end
      end
      WRITEBACK: begin
        busy        = 1'b1;
        issued_d    = 1'b1;
        mem_write_d = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (mem_done) begin
          state_d     = FETCH;
          issued_d    = 1'b0;
          mem_write_d = 1'b0;
          mem_wdata_d = '0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ADDRESS[ADDR_W-1:OFFSET_W];
        end
      end
      FETCH: begin
        busy       = 1'b1;
        issued_d   = 1'b1;
        mem_read_d = 1'b1;
        mem_addr_d = mem_addr_q;
        if (mem_done) begin
          fill_en    = 1'b1;
          state_d    = UPDATE;
          issued_d   = 1'b0;
          mem_read_d = 1'b0;
          mem_addr_d = '0;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      issued_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Reset also masks the stall so a held request does not show BUSYWAIT while in reset.
  assign BUSYWAIT      = RESET && busy;
  assign READ_DATA     = rdata;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed vector bench for dcache_ctrl
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITE_DATA;
  logic [7:0]  READ_DATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  dcache_ctrl #(.NUM_LINES(8), .ADDR_W(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITE_DATA    (WRITE_DATA),
    .READ_DATA     (READ_DATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory: busy rises one cycle after a request and stays up for 5 cycles.
  logic [31:0] mem [64];
  int          mem_cnt = 0;
  int          overlap = 0;

  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) mem_cnt <= mem_cnt + 1;
    else                       mem_cnt <= 0;
  end

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt >= 1) && (mem_cnt <= 5);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(negedge CLK) begin
    if (MEM_READ && MEM_WRITE) overlap <= overlap + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        miss;
    logic        wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  fetch_addr;
    logic [7:0]  rdata;
    logic [7:0]  dirty;
  } vec_t;

  vec_t vecs [10];

  logic        first_busy, saw_wb, saw_fetch, saw_update, timeout;
  logic [5:0]  got_wb_addr, got_fetch_addr;
  logic [31:0] got_wb_data;
  logic [7:0]  got_rdata;

  task automatic access(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    int stall;
    stall = 0;
    saw_wb = 0; saw_fetch = 0; saw_update = 0; timeout = 0;
    got_wb_addr = '0; got_wb_data = '0; got_fetch_addr = '0;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITE_DATA = wdata;
    #1;
    first_busy = BUSYWAIT;
    while (BUSYWAIT && !timeout) begin
      if (MEM_WRITE) begin
        saw_wb = 1; got_wb_addr = MEM_ADDRESS; got_wb_data = MEM_WRITEDATA;
      end
      if (MEM_READ) begin
        saw_fetch = 1; got_fetch_addr = MEM_ADDRESS;
      end
      if (saw_fetch && !MEM_READ && !MEM_WRITE) saw_update = 1;
      stall++;
      if (stall > 200) timeout = 1;
      @(negedge CLK); #1;
    end
    got_rdata = READ_DATA;
    if (saw_wb) mem[got_wb_addr] = got_wb_data;
    @(negedge CLK);
    READ = 0; WRITE = 0;
  endtask

  task automatic run_vec(input int i);
    access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    chk($sformatf("v%0d timeout", i), 32'(timeout), 32'd0);
    chk($sformatf("v%0d busy_in_request_cycle", i), 32'(first_busy), 32'(vecs[i].miss));
    chk($sformatf("v%0d fetch_seen", i), 32'(saw_fetch), 32'(vecs[i].miss));
    chk($sformatf("v%0d writeback_seen", i), 32'(saw_wb), 32'(vecs[i].wb));
    if (vecs[i].wb) begin
      chk($sformatf("v%0d wb_addr", i), 32'(got_wb_addr), 32'(vecs[i].wb_addr));
      chk($sformatf("v%0d wb_data", i), got_wb_data, vecs[i].wb_data);
    end
    if (vecs[i].miss) begin
      chk($sformatf("v%0d fetch_addr", i), 32'(got_fetch_addr), 32'(vecs[i].fetch_addr));
      chk($sformatf("v%0d update_cycle", i), 32'(saw_update), 32'd1);
    end
    chk($sformatf("v%0d read_data", i), 32'(got_rdata), 32'(vecs[i].rdata));
    chk($sformatf("v%0d dirty_bits", i), 32'(dut.u_lines.dirty_q), 32'(vecs[i].dirty));
  endtask

  initial begin
    int wait_cnt;
    for (int a = 0; a < 64; a++) begin
      logic [7:0] b;
      b = 8'(a);
      mem[a] = {b ^ 8'hC0, b ^ 8'h80, b ^ 8'h40, b};
    end

    //          rd    wr    addr   wdata  miss  wb    wb_a   wb_data        f_a    rdata  dirty
    vecs[0] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 1'b0, 6'h00, 32'h0,         6'h09, 8'h49, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h26, 8'hAB, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'h00, 8'h02};
    vecs[2] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'hAB, 8'h02};
    vecs[3] = '{1'b1, 1'b0, 8'hA4, 8'h00, 1'b1, 1'b1, 6'h09, 32'hC9AB4909,  6'h29, 8'h29, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 8'h10, 8'h5C, 1'b1, 1'b0, 6'h00, 32'h0,         6'h04, 8'h00, 8'h10};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'h5C, 8'h10};
    vecs[6] = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'hC4, 8'h10};
    vecs[7] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 1'b0, 6'h00, 32'h0,         6'h09, 8'h49, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'hAB, 8'h00};
    vecs[9] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 8'h77, 8'h02};

    RESET = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITE_DATA = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("reset MEM_READ", 32'(MEM_READ), 32'd0);
    chk("reset MEM_WRITE", 32'(MEM_WRITE), 32'd0);
    chk("reset MEM_ADDRESS", 32'(MEM_ADDRESS), 32'd0);
    chk("reset MEM_WRITEDATA", MEM_WRITEDATA, 32'd0);
    chk("reset READ_DATA", 32'(READ_DATA), 32'd0);
    @(negedge CLK);
    RESET = 1;

    for (int i = 0; i <= 6; i++) run_vec(i);

    // Reset asserted mid-FETCH: request and stall must vanish immediately.
    @(negedge CLK);
    READ = 1; ADDRESS = 8'h25;
    wait_cnt = 0;
    while (!MEM_READ && wait_cnt < 50) begin
      @(negedge CLK); wait_cnt++;
    end
    chk("midfetch reached FETCH", 32'(MEM_READ), 32'd1);
    repeat (2) @(negedge CLK);
    RESET = 0;
    #1;
    chk("midfetch MEM_READ drop", 32'(MEM_READ), 32'd0);
    chk("midfetch BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("midfetch state", 32'(dut.state_q), 32'(IDLE));
    chk("midfetch MEM_ADDRESS", 32'(MEM_ADDRESS), 32'd0);
    chk("midfetch valid bits", 32'(dut.u_lines.valid_q), 32'd0);
    @(negedge CLK);
    READ = 0;
    RESET = 1;

    for (int i = 7; i <= 8; i++) run_vec(i);

    // READ and WRITE together on a hit act as a zero-stall store.
    @(negedge CLK);
    READ = 1; WRITE = 1; ADDRESS = 8'h26; WRITE_DATA = 8'h77;
    #1;
    chk("rw BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    READ = 0; WRITE = 0;
    #1;
    chk("rw MEM_READ", 32'(MEM_READ), 32'd0);
    chk("rw MEM_WRITE", 32'(MEM_WRITE), 32'd0);

    run_vec(9);

    chk("MEM_READ/MEM_WRITE overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
